fir_err_accum: RTL and testbench

FIR_ERR_ACCUM -- requirements
Module: fir_err_accum

---
 rtl/fir_err_accum_pkg.sv | 15 +
 rtl/fir_err_accum_if.sv | 30 +++
 rtl/fir_err_accum_absdiff.sv | 15 +
 rtl/fir_err_accum.sv | 139 +++++++++++++
 tb/tb_fir_err_accum.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_err_accum_pkg.sv
// Shared types and default sizes for the FIR approximate-adder error meter.
// Optional macro FIR_ERR_MAX_EN is consumed by fir_err_accum.
package fir_err_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_e;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_WIN_LOG2 = 8;

endpackage

// File: rtl/fir_err_accum_if.sv
// Bundle of sample-pair inputs and window results around fir_err_accum.
// master drives the pairs and start; slave is the meter side.
interface fir_err_accum_if
  import fir_err_accum_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
);

  logic                      start;
  logic                      in_valid;
  logic [WIDTH-1:0]          approx;
  logic [WIDTH-1:0]          exact;
  logic                      busy;
  logic                      done;
  logic [WIDTH+WIN_LOG2-1:0] err_sum;
  logic [WIN_LOG2:0]         err_cnt;
  logic [WIDTH-1:0]          err_max;

  modport master (
    output start, in_valid, approx, exact,
    input  busy, done, err_sum, err_cnt, err_max
  );

  modport slave (
    input  start, in_valid, approx, exact,
    output busy, done, err_sum, err_cnt, err_max
  );

endinterface

// File: rtl/fir_err_accum_absdiff.sv
// Combinational unsigned |a-b|; the result always fits WIDTH bits.
module fir_absdiff #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    if (a >= b) y = a - b;
    else        y = b - a;
  end

endmodule

// File: rtl/fir_err_accum.sv
// Windowed error meter: sum, count and (FIR_ERR_MAX_EN) max of |approx-exact|.
// Two-stage pipe: stage 1 absdiff register, stage 2 accumulators.
module fir_err_accum
  import fir_err_accum_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          approx,
  input  logic [WIDTH-1:0]          exact,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH+WIN_LOG2-1:0] err_sum,
  output logic [WIN_LOG2:0]         err_cnt,
  output logic [WIDTH-1:0]          err_max
);

  localparam int SW = WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] LAST = {1'b0, {WIN_LOG2{1'b1}}};

  state_e            state_q, state_d;
  logic [WIN_LOG2:0] cnt_q, cnt_d;
  logic              drn_q, drn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clr;

  logic              s1_v_q, s1_v_d;
  logic              s1_nz_q, s1_nz_d;
  logic [WIDTH-1:0]  s1_abs_q, s1_abs_d;

  logic [SW-1:0]     sum_q, sum_d;
  logic [WIN_LOG2:0] ecnt_q, ecnt_d;

  fir_absdiff #(.WIDTH(WIDTH)) u_absdiff (
    .a (approx),
    .b (exact),
    .y (s1_abs_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == FIN);
  end

  always_comb begin
    s1_v_d  = in_valid && (state_q == RUN);
    s1_nz_d = (approx != exact);
    sum_d   = sum_q;
    ecnt_d  = ecnt_q;
    if (clr) begin
      sum_d  = '0;
      ecnt_d = '0;
    end else if (s1_v_q) begin
      sum_d  = sum_q + {{WIN_LOG2{1'b0}}, s1_abs_q};
      ecnt_d = ecnt_q + {{WIN_LOG2{1'b0}}, s1_nz_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_nz_q  <= 1'b0;
      s1_abs_q <= '0;
      sum_q    <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drn_q    <= drn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      s1_v_q   <= s1_v_d;
      s1_nz_q  <= s1_nz_d;
      s1_abs_q <= s1_abs_d;
      sum_q    <= sum_d;
      ecnt_q   <= ecnt_d;
    end
  end

`ifdef FIR_ERR_MAX_EN
  logic [WIDTH-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (clr) max_d = '0;
    else if (s1_v_q && (s1_abs_q > max_q)) max_d = s1_abs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign err_max = max_q;
`else
  assign err_max = '0;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_sum = sum_q;
  assign err_cnt = ecnt_q;

endmodule

// File: tb/tb_fir_err_accum.sv
// Directed bench: small window (WIN_LOG2=2) plus default-size window.
module tb_fir_err_accum;

`ifdef FIR_ERR_MAX_EN
  localparam bit MX = 1'b1;
`else
  localparam bit MX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   ntest = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  fir_err_accum_if #(.WIDTH(16), .WIN_LOG2(2)) s ();
  fir_err_accum_if #(.WIDTH(16), .WIN_LOG2(8)) d ();

  fir_err_accum #(.WIDTH(16), .WIN_LOG2(2)) dut_s (
    .clk      (clk),
    .rst      (rst),
    .start    (s.start),
    .in_valid (s.in_valid),
    .approx   (s.approx),
    .exact    (s.exact),
    .busy     (s.busy),
    .done     (s.done),
    .err_sum  (s.err_sum),
    .err_cnt  (s.err_cnt),
    .err_max  (s.err_max)
  );

  fir_err_accum #(.WIDTH(16), .WIN_LOG2(8)) dut_d (
    .clk      (clk),
    .rst      (rst),
    .start    (d.start),
    .in_valid (d.in_valid),
    .approx   (d.approx),
    .exact    (d.exact),
    .busy     (d.busy),
    .done     (d.done),
    .err_sum  (d.err_sum),
    .err_cnt  (d.err_cnt),
    .err_max  (d.err_max)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair_s(input logic [15:0] a, input logic [15:0] e);
    s.in_valid = 1'b1;
    s.approx   = a;
    s.exact    = e;
    tick();
    s.in_valid = 1'b0;
  endtask

  task automatic start_s();
    s.start = 1'b1;
    tick();
    s.start = 1'b0;
  endtask

  task automatic outs_s(input string tag, input logic [31:0] sum,
                        input logic [31:0] cnt, input logic [31:0] mx);
    chk({tag, "_sum"}, 32'(s.err_sum), sum);
    chk({tag, "_cnt"}, 32'(s.err_cnt), cnt);
    chk({tag, "_max"}, 32'(s.err_max), MX ? mx : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    s.start = 1'b0; s.in_valid = 1'b0; s.approx = '0; s.exact = '0;
    d.start = 1'b0; d.in_valid = 1'b0; d.approx = '0; d.exact = '0;
    tick();
    tick();
    chk("rst_busy", 32'(s.busy), 32'd0);
    chk("rst_done", 32'(s.done), 32'd0);
    outs_s("rst", 0, 0, 0);
    rst = 1'b0;
    tick();

    // equal pairs: zero error, done on the third edge after the last pair
    start_s();
    chk("eq_busy_run", 32'(s.busy), 32'd1);
    for (int i = 0; i < 4; i++) pair_s(16'h1234, 16'h1234);
    chk("eq_done_e1", 32'(s.done), 32'd0);
    chk("eq_busy_e1", 32'(s.busy), 32'd1);
    tick();
    chk("eq_done_e2", 32'(s.done), 32'd0);
    chk("eq_busy_e2", 32'(s.busy), 32'd1);
    tick();
    chk("eq_done_e3", 32'(s.done), 32'd1);
    chk("eq_busy_fin", 32'(s.busy), 32'd0);
    outs_s("eq", 0, 0, 0);
    tick();
    chk("eq_done_pulse", 32'(s.done), 32'd0);

    // mixed errors including full-scale difference
    start_s();
    pair_s(16'd10, 16'd7);
    pair_s(16'd7, 16'd10);
    pair_s(16'd5, 16'd5);
    pair_s(16'd0, 16'hFFFF);
    tick();
    tick();
    chk("mix_done", 32'(s.done), 32'd1);
    outs_s("mix", 65541, 3, 65535);
    tick();
    tick();
    outs_s("mix_hold", 65541, 3, 65535);

    // in_valid toggling: window stalls, busy stays high
    start_s();
    for (int i = 0; i < 4; i++) begin
      pair_s(16'd1, 16'd2);
      chk("gap_busy_v", 32'(s.busy), 32'd1);
      if (i < 3) begin
        tick();
        chk("gap_busy_g", 32'(s.busy), 32'd1);
        chk("gap_done_g", 32'(s.done), 32'd0);
      end
    end
    tick();
    chk("gap_done_e2", 32'(s.done), 32'd0);
    tick();
    chk("gap_done", 32'(s.done), 32'd1);
    outs_s("gap", 4, 4, 1);

    // in_valid in IDLE is ignored
    tick();
    pair_s(16'd9, 16'd0);
    tick();
    chk("idle_v_busy", 32'(s.busy), 32'd0);
    outs_s("idle_v", 4, 4, 1);

    // start with in_valid: that pair is not counted; start in RUN ignored
    s.start = 1'b1; s.in_valid = 1'b1; s.approx = 16'd100; s.exact = 16'd0;
    tick();
    s.start = 1'b0; s.in_valid = 1'b0;
    chk("sv_busy", 32'(s.busy), 32'd1);
    pair_s(16'd0, 16'd5);
    s.start = 1'b1;
    pair_s(16'd3, 16'd0);
    s.start = 1'b0;
    outs_s("run_start", 5, 1, 5);
    chk("run_start_busy", 32'(s.busy), 32'd1);

    // reset mid-window: everything clears, no done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(s.busy), 32'd0);
    chk("mid_rst_done", 32'(s.done), 32'd0);
    outs_s("mid_rst", 0, 0, 0);
    tick();
    tick();
    tick();
    chk("mid_rst_nodone", 32'(s.done), 32'd0);

    // clean window after reset
    start_s();
    pair_s(16'd2, 16'd0);
    pair_s(16'd0, 16'd0);
    pair_s(16'd0, 16'd1);
    pair_s(16'd7, 16'd7);
    tick();
    tick();
    chk("clean_done", 32'(s.done), 32'd1);
    outs_s("clean", 3, 2, 2);

    // default size: 256 full-scale errors, no wrap
    d.start = 1'b1;
    tick();
    d.start = 1'b0;
    d.approx = 16'hFFFF;
    d.exact  = 16'h0000;
    d.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    d.in_valid = 1'b0;
    tick();
    tick();
    chk("big_done", 32'(d.done), 32'd1);
    chk("big_sum", 32'(d.err_sum), 32'h00FF_FF00);
    chk("big_cnt", 32'(d.err_cnt), 32'd256);
    chk("big_max", 32'(d.err_max), MX ? 32'h0000_FFFF : 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
